reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares one WORD_SIZE storage register among NUM_REQ write requesters.
//  Round-robin req/gnt/ack handshake with an optional multi-cycle lock.
//  Sits between pipeline/CSR writers and a single shared state word.
//  Drives the registered value q to all consumers.
// PARAMETERS
//  WORD_SIZE   from src/parameters.v  data width (shared include)
//  NUM_REQ     4                      number of requesters, >=2
//  LOCK_LIMIT  8                      max consecutive LOCKED writes (timeout build only)
// PORTS
//  clk    in   1                   rising-edge clock
//  reset  in   1                   asynchronous, active-low; 0 = reset asserted
//  req    in   NUM_REQ             write request per requester, level, held until ack
//  lock   in   NUM_REQ             owner keeps the grant while req&lock stay high
//  wdata  in   NUM_REQ*WORD_SIZE   requester i data at [i*WORD_SIZE +: WORD_SIZE]
//  gnt    out  NUM_REQ             registered one-hot grant
//  ack    out  NUM_REQ             one-cycle pulse: requester's write committed to q
//  owner  out  $clog2(NUM_REQ)     index of current/last grantee
//  busy   out  1                   state != IDLE
//  q      out  WORD_SIZE           shared register value
// BEHAVIOUR
//  Reset (reset=0, async): q=0, gnt=0, ack=0, owner=0, busy=0, state=IDLE,
//   rr pointer=NUM_REQ-1, so requester 0 wins first.
//  States: IDLE, GRANT, LOCKED.
//  IDLE: if |req, pick the first set req scanning from ptr+1, wrapping
//   -> at the next edge: gnt=onehot(win), owner=win, state=GRANT. No req -> stay.
//  GRANT edge: if req[owner]: q<=wdata[owner], ack[owner]=1 next cycle, ptr<=owner;
//   then if lock[owner] -> LOCKED, else gnt=0 -> IDLE.
//   If req[owner] has dropped: abort; no write, no ack, ptr unchanged, -> IDLE.
//  LOCKED edge: if req[owner]&lock[owner]: write q, ack[owner] pulses, stay.
//   Otherwise gnt=0 and state -> IDLE with no write.
//  Latency: req to gnt = 1 edge; req to q/ack = 2 edges.
//   Unlocked grants are spaced 2 cycles apart (IDLE turnaround bubble).
//  ack is asserted only for the owner and never together with any other bit.
//  gnt is always one-hot or zero.
//  Requests arriving while busy wait; no request is lost while req is held.
//  Reset asserted mid-GRANT/LOCKED: all outputs clear immediately and no ack is produced.
// CONFIGURATION
//  REG_ARB_LOCK_TIMEOUT_EN defined: a counter limits LOCKED to LOCK_LIMIT writes,
//   counting the GRANT write as 1. After the last write -> IDLE; in that next
//   arbitration the owner is masked if any other req is set.
//  Undefined: no counter; LOCKED lasts while req&lock hold. LOCK_LIMIT is ignored.
// STRUCTURE
//  State encodings (ARB_IDLE/ARB_GRANT/ARB_LOCKED, 2 bits) go in src/parameters.v
//   next to WORD_SIZE.
//  Sub-module rr_priority_picker: combinational; inputs (req, ptr, mask),
//   outputs (valid, win index).
//  The q register is internal to this block: it needs a write enable and the
//   active-low reset.
// TESTING (NUM_REQ=4, WORD_SIZE=32)
//  Reset: hold reset=0 with random req -> q=0, gnt=0, ack=0, busy=0, owner=0.
//   Release reset, req=4'b1111 -> first gnt=4'b0001.
//  Single request: req=4'b0100, wdata[2]=32'hDEADBEEF
//   -> gnt=4'b0100 after 1 edge; q=32'hDEADBEEF and ack=4'b0100 after 2 edges.
//  Fairness: req=4'b1111 held, lock=0 -> gnt order 0,1,2,3,0 at 2-cycle spacing,
//   with each ack exactly once per round.
//  Lock: req[1]=lock[1]=1 for 5 writes while req[3]=1 -> 5 consecutive ack[1] pulses
//   and gnt[3] stays 0. Drop lock[1] -> IDLE, then gnt=4'b1000.
//  Abort: drop req[2] during GRANT -> no ack, q unchanged, next gnt from ptr order.
//  Reset mid-LOCKED -> outputs 0 within the same cycle.
//   With REG_ARB_LOCK_TIMEOUT_EN and LOCK_LIMIT=8: a permanent lock by requester 0
//   with req[1] pending -> 8 acks, then gnt=4'b0010.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// ============================================================================
// Module      : reg_write_arbiter_pkg
// Description : Shared word width and arbiter state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_write_arbiter_pkg;

    localparam int unsigned C_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker, scanning from ptr+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               valid,
    output logic [IDX_W-1:0]   win
);

    logic [NUM_REQ-1:0] w_req_masked;
    logic [IDX_W-1:0]   w_idx;
    int                 w_sum;

    assign w_req_masked = req & ~mask;

    // Walk from the farthest candidate to the nearest so the nearest overwrites.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        w_sum = 0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= int'(NUM_REQ)) begin
                w_sum = w_sum - int'(NUM_REQ);
            end
            w_idx = IDX_W'(w_sum);
            if (w_req_masked[w_idx]) begin
                valid = 1'b1;
                win   = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin req/gnt/ack arbiter owning one shared register.
//               Define REG_ARB_LOCK_TIMEOUT_EN to bound LOCKED to LOCK_LIMIT writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = C_WORD_SIZE,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LOCK_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           lock,
    input  logic [NUM_REQ*WORD_SIZE-1:0] wdata,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           ack,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         busy,
    output logic [WORD_SIZE-1:0]         q
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_chk_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (LOCK_LIMIT < 1) begin : g_chk_lock_limit
        $error("LOCK_LIMIT must be at least 1");
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;

    logic [WORD_SIZE-1:0] w_words [NUM_REQ];
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [NUM_REQ-1:0]   w_mask;
    logic                 w_valid;
    logic [IDX_W-1:0]     w_win;
    logic                 w_grant_stay;
    logic                 w_lock_expire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_words[i] = wdata[i*WORD_SIZE +: WORD_SIZE];
    end

    assign w_owner_oh = onehot(owner_q);

`ifdef REG_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(LOCK_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // After a timed-out lock, the old owner yields once if anyone else is waiting.
    assign w_mask        = (expired_q && ((req & ~w_owner_oh) != '0)) ? w_owner_oh : '0;
    assign w_grant_stay  = lock[owner_q] && (LOCK_LIMIT > 1);
    assign w_lock_expire = (int'(cnt_q) + 1) >= int'(LOCK_LIMIT);
`else
    assign w_mask        = '0;
    assign w_grant_stay  = lock[owner_q];
    assign w_lock_expire = 1'b0;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (w_mask),
        .valid (w_valid),
        .win   (w_win)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
        cnt_d     = cnt_q;
        expired_d = expired_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (w_valid) begin
                    gnt_d   = onehot(w_win);
                    owner_d = w_win;
                    state_d = ARB_GRANT;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                    expired_d = 1'b0;
`endif
                end
            end
            ARB_GRANT: begin
                if (req[owner_q]) begin
                    data_d = w_words[owner_q];
                    ack_d  = w_owner_oh;
                    ptr_d  = owner_q;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                    cnt_d     = CNT_W'(1);
                    expired_d = lock[owner_q] && !w_grant_stay;
`endif
                    if (w_grant_stay) begin
                        state_d = ARB_LOCKED;
                    end else begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end else begin
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (req[owner_q] && lock[owner_q]) begin
                    data_d = w_words[owner_q];
                    ack_d  = w_owner_oh;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                    if (w_lock_expire) begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                        expired_d = 1'b1;
`endif
                    end
                end else begin
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

`ifdef REG_ARB_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end
`endif

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign busy  = (state_q != ARB_IDLE);
    assign q     = data_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Directed bench with a write scoreboard for reg_write_arbiter.
//               Honours REG_ARB_LOCK_TIMEOUT_EN for the lock-limit scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int WS = 32;
    localparam int LL = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR-1:0]    lock;
    logic [NR*WS-1:0] wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    ack;
    logic [1:0]       owner;
    logic             busy;
    logic [WS-1:0]    q;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int            idx;
        logic [WS-1:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .WORD_SIZE  (WS),
        .NUM_REQ    (NR),
        .LOCK_LIMIT (LL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .owner (owner),
        .busy  (busy),
        .q     (q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setw(input int i, input logic [WS-1:0] d);
        wdata[i*WS +: WS] = d;
    endtask

    task automatic expect_wr(input int i);
        exp_t e;
        e.idx  = i;
        e.data = wdata[i*WS +: WS];
        sb.push_back(e);
    endtask

    // Every ack must match the oldest expected write, both in index and value.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ack", 64'(ack), 64'd1 << e.idx);
                    chk("sb_q", 64'(q), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_lock;
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        for (int i = 0; i < NR; i++) setw(i, 32'hA000_0000 + 32'(i));

        // Reset held with random requests
        repeat (3) begin
            req = 4'($urandom_range(0, 15));
            step();
        end
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);

        // Fairness: all four requesting, no lock
        req = 4'b1111;
        for (int i = 0; i < NR; i++) expect_wr(i);
        reset = 1'b1;
        for (int r = 0; r < NR; r++) begin
            step();
            chk("fair_gnt", 64'(gnt), 64'd1 << r);
            chk("fair_owner", 64'(owner), 64'(r));
            step();
            chk("fair_gap", 64'(gnt), 64'd0);
        end
        step();
        chk("fair_wrap", 64'(gnt), 64'b0001);
        req = '0;
        step();
        chk("abort0_gnt", 64'(gnt), 64'd0);
        chk("abort0_q", 64'(q), 64'hA000_0003);
        chk("abort0_busy", 64'(busy), 64'd0);

        // Single request latency
        setw(2, 32'hDEAD_BEEF);
        req = 4'b0100;
        expect_wr(2);
        step();
        chk("single_gnt", 64'(gnt), 64'b0100);
        chk("single_q_hold", 64'(q), 64'hA000_0003);
        step();
        chk("single_q", 64'(q), 64'hDEAD_BEEF);
        chk("single_ack", 64'(ack), 64'b0100);
        req = '0;
        step();
        chk("single_idle", 64'(busy), 64'd0);

        // Locked owner holds off a pending requester
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        chk("lock_gnt", 64'(gnt), 64'b0010);
        req = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            setw(1, 32'h1111_0000 + 32'(k));
            expect_wr(1);
            step();
            chk("lock_ack", 64'(ack), 64'b0010);
            chk("lock_gnt_held", 64'(gnt), 64'b0010);
        end
        lock = '0;
        step();
        chk("unlock_idle", 64'(gnt), 64'd0);
        chk("unlock_q", 64'(q), 64'h1111_0004);
        step();
        chk("unlock_next_gnt", 64'(gnt), 64'b1000);
        req = 4'b1000;
        expect_wr(3);
        step();
        chk("unlock_next_ack", 64'(ack), 64'b1000);
        req = '0;
        step();

        // Abort: grantee withdraws before commit; pointer must stay at 3
        setw(2, 32'h2222_2222);
        req = 4'b0100;
        step();
        chk("abort_gnt", 64'(gnt), 64'b0100);
        req = 4'b1001;
        step();
        chk("abort_ack", 64'(ack), 64'd0);
        chk("abort_q", 64'(q), 64'hA000_0003);
        chk("abort_gnt_drop", 64'(gnt), 64'd0);
        expect_wr(0);
        step();
        chk("abort_next_gnt", 64'(gnt), 64'b0001);
        step();
        chk("abort_next_ack", 64'(ack), 64'b0001);
        req = '0;
        step();

        // Reset while LOCKED clears outputs without waiting for a clock
        setw(0, 32'h4444_4444);
        req  = 4'b0001;
        lock = 4'b0001;
        step();
        chk("rl_gnt", 64'(gnt), 64'b0001);
        step();
        chk("rl_ack", 64'(ack), 64'b0001);
        chk("rl_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("rl_gnt_clr", 64'(gnt), 64'd0);
        chk("rl_ack_clr", 64'(ack), 64'd0);
        chk("rl_busy_clr", 64'(busy), 64'd0);
        chk("rl_q_clr", 64'(q), 64'd0);
        chk("rl_owner_clr", 64'(owner), 64'd0);
        req  = '0;
        lock = '0;
        step();
        reset = 1'b1;
        step();

        // Permanent lock by requester 0 with requester 1 waiting
`ifdef REG_ARB_LOCK_TIMEOUT_EN
        n_lock = LL;
`else
        n_lock = LL + 2;
`endif
        req  = 4'b0011;
        lock = 4'b0001;
        step();
        chk("to_gnt", 64'(gnt), 64'b0001);
        for (int k = 0; k < n_lock; k++) begin
            setw(0, 32'h3333_0000 + 32'(k));
            expect_wr(0);
            step();
            chk("to_ack", 64'(ack), 64'b0001);
        end
`ifdef REG_ARB_LOCK_TIMEOUT_EN
        chk("to_release", 64'(gnt), 64'd0);
        step();
        chk("to_next_gnt", 64'(gnt), 64'b0010);
`else
        chk("lock_hold", 64'(gnt), 64'b0001);
        lock = '0;
        step();
        chk("lock_release", 64'(gnt), 64'd0);
        step();
        chk("lock_next_gnt", 64'(gnt), 64'b0010);
`endif
        req  = '0;
        lock = '0;
        step();
        step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
